stream_demux: RTL
=================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001: The module SHALL have parameter DataWidth, default 32, meaning payload width in bits.
REQ-002: The module SHALL have parameter NumSel, default 4, meaning number of output ports.
REQ-003: The module SHALL have derived parameter NumSelWidth, default $clog2(NumSel), meaning select width; it is not user-overridden.
REQ-004: The module SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005: The module SHALL have port rst_i, input, 1, reset; it is synchronous and active-high.
REQ-006: The module SHALL have port sel_i, input, NumSelWidth, destination index qualified by valid_i.
REQ-007: The module SHALL have port data_i, input, DataWidth, input payload.
REQ-008: The module SHALL have port valid_i, input, 1, input payload valid.
REQ-009: The module SHALL have port ready_o, output, 1, input accept.
REQ-010: The module SHALL have port data_o, output, NumSel x DataWidth (packed, [NumSel-1:0][DataWidth-1:0]), per-port payload.
REQ-011: The module SHALL have port valid_o, output, NumSel, per-port valid.
REQ-012: The module SHALL have port ready_i, input, NumSel, per-port downstream ready.
REQ-013: The module SHALL have port err_o, output, 1, sticky out-of-range select flag; the port is present only with STREAM_DEMUX_ERR_EN (REQ-032).

Function
REQ-014: The module SHALL hold, per output k, a one-entry register: full[k] and buf[k] (DataWidth bits).
REQ-015: The module SHALL drive valid_o[k] = full[k] and data_o[k] = buf[k], both directly from registers.
REQ-016: Input transfer SHALL occur in a cycle where valid_i && ready_o; output pop SHALL occur on port k in a cycle where valid_o[k] && ready_i[k].
REQ-017: For in-range sel_i (< NumSel), the module SHALL drive ready_o = !full[sel_i] || ready_i[sel_i], combinationally.
REQ-018: On input transfer to port s, the module SHALL set buf[s] <= data_i and full[s] <= 1 at the next edge; data_i appears on data_o[s] after 1 cycle.
REQ-019: On pop of port k with no push to k in the same cycle, the module SHALL clear full[k] at the next edge.
REQ-020: On simultaneous pop and push to the same port, full[k] SHALL stay 1 and buf[k] SHALL take the new data; the port sustains 1 transfer/cycle.
REQ-021: Push to port s and pops on other ports in the same cycle SHALL be independent; all SHALL take effect.
REQ-022: While valid_o[k] && !ready_i[k], data_o[k] SHALL remain stable.
REQ-023: A full port with ready_i low SHALL stall only inputs addressed to it (ready_o low); other ports keep draining.
REQ-024: Out-of-range sel_i (>= NumSel, possible only when NumSel is not a power of two) SHALL produce ready_o = 1, consume the beat and discard it; no buf/full changes.
REQ-025: The module SHALL not reorder beats to the same port; each accepted beat appears exactly once.
REQ-026: NumSel = 1 SHALL be supported, with NumSelWidth treated as 1 and sel_i ignored except for REQ-024 range check (sel_i = 1 is out of range).

Reset
REQ-027: While rst_i = 1 at a clock edge, the module SHALL clear all full[k] to 0, all buf[k] to 0 and err_o to 0.
REQ-028: During reset, the module SHALL drive ready_o = 0.
REQ-029: Reset asserted mid-operation SHALL discard all buffered beats; the module SHALL perform no pops or pushes in that cycle.
REQ-030: After reset release, valid_o SHALL be all 0 and data_o all 0 until the first accepted beat.

Configuration
REQ-031: The module SHALL compile the error feature in with macro STREAM_DEMUX_ERR_EN.
REQ-032: With STREAM_DEMUX_ERR_EN defined, err_o SHALL exist, set 1 on the edge after any out-of-range input transfer, and hold until reset.
REQ-033: Without STREAM_DEMUX_ERR_EN, err_o SHALL be absent; out-of-range beats are silently dropped per REQ-024; all else SHALL be identical.

Verification
REQ-034: Bench SHALL cover: reset, then push sel=2, data=0xA5A5A5A5 with ready_i=4'b0100 -> next cycle valid_o=4'b0100, data_o[2]=0xA5A5A5A5, one-cycle pop.
REQ-035: Bench SHALL cover: ready_i[1]=0, push 0x11 then 0x22 to sel=1 -> second beat sees ready_o=0; data_o[1] holds 0x11; raising ready_i[1] pops 0x11, then accepts 0x22.
REQ-036: Bench SHALL cover: ready_i=4'b1111, 8 back-to-back beats sel=3 data 0..7 -> ready_o=1 every cycle, port 3 outputs 0..7 in order, 1 beat/cycle.
REQ-037: Bench SHALL cover: port 0 full stalled, push to sel=1 -> ready_o=1, port 1 valid next cycle; port 0 data unchanged.
REQ-038: Bench SHALL cover: NumSel=3, sel=3 beat with macro -> ready_o=1, no valid_o change, err_o=1 next cycle and sticky; without macro -> beat dropped, no err_o.
REQ-039: Bench SHALL cover: rst_i asserted while ports 0 and 2 full -> next cycle valid_o=0, data_o=0, ready_o=0 during reset.

Source files
------------

// File: rtl/stream_demux.sv
// One-to-NumSel stream demultiplexer with a one-entry skid register per output port.
// Optional sticky out-of-range select flag err_o is built in with STREAM_DEMUX_ERR_EN.
module stream_demux #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumSel = 4,
  localparam int unsigned NumSelWidth = (NumSel > 1) ? $clog2(NumSel) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumSelWidth-1:0]           sel_i,
  input  logic [DataWidth-1:0]             data_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  output logic [NumSel-1:0][DataWidth-1:0] data_o,
  output logic [NumSel-1:0]                valid_o,
  input  logic [NumSel-1:0]                ready_i
`ifdef STREAM_DEMUX_ERR_EN
  ,
  output logic                             err_o
`endif
);

  logic [NumSel-1:0]                full_q, full_d;
  logic [NumSel-1:0][DataWidth-1:0] buf_q, buf_d;

  logic [NumSel-1:0] sel_hit;
  logic [NumSel-1:0] port_rdy;
  logic [NumSel-1:0] push;
  logic [NumSel-1:0] pop;
  logic              in_range;
  logic              xfer;

  // Decode by comparison rather than indexing so out-of-range selects never index past NumSel.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < NumSel; k++) begin
      sel_hit[k] = (sel_i == NumSelWidth'(k));
    end
  end

  assign in_range = |sel_hit;
  assign port_rdy = ~full_q | ready_i;

  // Out-of-range beats are always accepted and dropped.
  assign ready_o = !rst_i && (in_range ? |(sel_hit & port_rdy) : 1'b1);
  assign xfer    = valid_i && ready_o;
  assign push    = sel_hit & {NumSel{xfer}};
  assign pop     = full_q & ready_i;

  always_comb begin
    full_d = full_q;
    buf_d  = buf_q;
    for (int k = 0; k < NumSel; k++) begin
      full_d[k] = push[k] | (full_q[k] & ~pop[k]);
      if (push[k]) begin
        buf_d[k] = data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= '0;
      buf_q  <= '0;
    end else begin
      full_q <= full_d;
      buf_q  <= buf_d;
    end
  end

  assign valid_o = full_q;
  assign data_o  = buf_q;

`ifdef STREAM_DEMUX_ERR_EN
  logic err_q, err_d;

  assign err_d = err_q | (xfer & ~in_range);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule
